// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation macroblock scheduler.
package me_pkg;

  localparam int MACRO_DIM_DEF  = 16;
  localparam int SEARCH_DIM_DEF = 48;
  localparam int FRAME_W_MB_DEF = 8;
  localparam int FRAME_H_MB_DEF = 6;

  localparam int SEARCH_RANGE = SEARCH_DIM_DEF - MACRO_DIM_DEF;

  localparam int MB_X_W = $clog2(FRAME_W_MB_DEF);
  localparam int MB_Y_W = $clog2(FRAME_H_MB_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_DRAIN
  } me_sched_state_t;

  typedef struct packed {
    logic [MB_X_W-1:0] mb_x;
    logic [MB_Y_W-1:0] mb_y;
    logic [7:0]        mv_x;
    logic [7:0]        mv_y;
    logic [15:0]       sad;
  } me_result_t;

endpackage

// File: rtl/me_win_clamp.sv
// Per-axis MB pixel origin and search-window origin, clamped to the frame.
module me_win_clamp #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int FRAME_MB   = 8,
  parameter int IDX_W      = 3
) (
  input  logic [IDX_W-1:0] mb_idx,
  output logic [15:0]      mb_pix,
  output logic [15:0]      win
);

  localparam int HALF    = (SEARCH_DIM - MACRO_DIM) / 2;
  localparam int MAX_ORG = FRAME_MB * MACRO_DIM - SEARCH_DIM;

  logic signed [17:0] raw;

  // Centre the window on the MB, then pull it back inside the frame edges.
  always_comb begin
    mb_pix = 16'(mb_idx) * 16'(MACRO_DIM);
    raw    = $signed({2'b00, mb_pix}) - $signed(18'(HALF));
    if (raw < 0) begin
      win = '0;
    end else if (raw > $signed(18'(MAX_ORG))) begin
      win = 16'(MAX_ORG);
    end else begin
      win = raw[15:0];
    end
  end

endmodule

// File: rtl/me_mb_sched.sv
// Raster-order macroblock scheduler: loads each MB/window, runs `me`,
// converts the result to a true motion vector and holds it in a one-entry slot.
module me_mb_sched
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = MACRO_DIM_DEF,
  parameter int SEARCH_DIM = SEARCH_DIM_DEF,
  parameter int FRAME_W_MB = FRAME_W_MB_DEF,
  parameter int FRAME_H_MB = FRAME_H_MB_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          ld_req,
  output logic [15:0]                   ld_mb_x,
  output logic [15:0]                   ld_mb_y,
  output logic [15:0]                   ld_win_x,
  output logic [15:0]                   ld_win_y,
  input  logic                          ld_done,
  output logic                          me_start,
  input  logic                          me_done,
  input  logic [5:0]                    me_mv_x,
  input  logic [5:0]                    me_mv_y,
  input  logic [15:0]                   me_min_sad,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(FRAME_W_MB)-1:0] res_mb_x,
  output logic [$clog2(FRAME_H_MB)-1:0] res_mb_y,
  output logic [7:0]                    res_mv_x,
  output logic [7:0]                    res_mv_y,
  output logic [15:0]                   res_sad
);

  localparam int XW = $clog2(FRAME_W_MB);
  localparam int YW = $clog2(FRAME_H_MB);

  me_sched_state_t state_q, state_d;
  logic [XW-1:0]   mb_x_q, mb_x_d;
  logic [YW-1:0]   mb_y_q, mb_y_d;
  logic            res_valid_q, res_valid_d;
  me_result_t      res_q, res_d;

  logic [15:0] mb_pix_x, mb_pix_y, win_x, win_y;
  logic [7:0]  mv_x, mv_y;
  logic        handshake, slot_free, capture, last_mb;

  me_win_clamp #(
    .MACRO_DIM (MACRO_DIM),
    .SEARCH_DIM(SEARCH_DIM),
    .FRAME_MB  (FRAME_W_MB),
    .IDX_W     (XW)
  ) u_clamp_x (
    .mb_idx(mb_x_q),
    .mb_pix(mb_pix_x),
    .win   (win_x)
  );

  me_win_clamp #(
    .MACRO_DIM (MACRO_DIM),
    .SEARCH_DIM(SEARCH_DIM),
    .FRAME_MB  (FRAME_H_MB),
    .IDX_W     (YW)
  ) u_clamp_y (
    .mb_idx(mb_y_q),
    .mb_pix(mb_pix_y),
    .win   (win_y)
  );

  // The true vector always fits in 8 signed bits, so modulo-256 arithmetic is exact.
  assign mv_x = 8'(win_x) + 8'(me_mv_x) - 8'(mb_pix_x);
  assign mv_y = 8'(win_y) + 8'(me_mv_y) - 8'(mb_pix_y);

  assign handshake = res_valid_q && res_ready;
  assign slot_free = !res_valid_q || res_ready;
  assign capture   = (state_q == ST_RUN) && me_done;
  assign last_mb   = (mb_x_q == XW'(FRAME_W_MB - 1)) && (mb_y_q == YW'(FRAME_H_MB - 1));

  always_comb begin
    state_d     = state_q;
    mb_x_d      = mb_x_q;
    mb_y_d      = mb_y_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;

    // Capture is applied after the handshake clear so a same-cycle pair keeps the slot full.
    if (handshake) begin
      res_valid_d = 1'b0;
    end
    if (capture) begin
      res_valid_d = 1'b1;
      res_d.mb_x  = MB_X_W'(mb_x_q);
      res_d.mb_y  = MB_Y_W'(mb_y_q);
      res_d.mv_x  = mv_x;
      res_d.mv_y  = mv_y;
      res_d.sad   = me_min_sad;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          mb_x_d  = '0;
          mb_y_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_done) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (slot_free) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (me_done) begin
          if (last_mb) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_LOAD;
            if (mb_x_q == XW'(FRAME_W_MB - 1)) begin
              mb_x_d = '0;
              mb_y_d = mb_y_q + 1'b1;
            end else begin
              mb_x_d = mb_x_q + 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (!res_valid_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mb_x_q      <= '0;
      mb_y_q      <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      mb_x_q      <= mb_x_d;
      mb_y_q      <= mb_y_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign ld_req     = (state_q == ST_LOAD);
  assign me_start   = (state_q == ST_ARM) && slot_free;
  assign frame_done = (state_q == ST_DRAIN) && !res_valid_q;

  assign ld_mb_x  = mb_pix_x;
  assign ld_mb_y  = mb_pix_y;
  assign ld_win_x = win_x;
  assign ld_win_y = win_y;

  assign res_valid = res_valid_q;
  assign res_mb_x  = XW'(res_q.mb_x);
  assign res_mb_y  = YW'(res_q.mb_y);
  assign res_mv_x  = res_q.mv_x;
  assign res_mv_y  = res_q.mv_y;
  assign res_sad   = res_q.sad;

endmodule

// File: tb/tb_me_mb_sched.sv
// Randomized scoreboard bench for me_mb_sched with behavioural loader and `me` responders.
module tb_me_mb_sched;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int MD  = 16;
  localparam int SD  = 48;
  localparam int NMB = W * H;
  localparam int FRAME_LIMIT = 5000;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        busy, frame_done, ld_req, ld_done, me_start, me_done;
  logic [15:0] ld_mb_x, ld_mb_y, ld_win_x, ld_win_y;
  logic [5:0]  me_mv_x, me_mv_y;
  logic [15:0] me_min_sad;
  logic        res_valid, res_ready;
  logic [2:0]  res_mb_x, res_mb_y;
  logic [7:0]  res_mv_x, res_mv_y;
  logic [15:0] res_sad;

  me_mb_sched #(
    .MACRO_DIM (MD),
    .SEARCH_DIM(SD),
    .FRAME_W_MB(W),
    .FRAME_H_MB(H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .busy       (busy),
    .frame_done (frame_done),
    .ld_req     (ld_req),
    .ld_mb_x    (ld_mb_x),
    .ld_mb_y    (ld_mb_y),
    .ld_win_x   (ld_win_x),
    .ld_win_y   (ld_win_y),
    .ld_done    (ld_done),
    .me_start   (me_start),
    .me_done    (me_done),
    .me_mv_x    (me_mv_x),
    .me_mv_y    (me_mv_y),
    .me_min_sad (me_min_sad),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_mb_x   (res_mb_x),
    .res_mb_y   (res_mb_y),
    .res_mv_x   (res_mv_x),
    .res_mv_y   (res_mv_y),
    .res_sad    (res_sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mb_x;
    int mb_y;
    int mv_x;
    int mv_y;
    int sad;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  int  ld_lat = 5;
  int  me_lat = 5;
  bit  rand_lat = 0;
  int  ready_mode = 0;
  bit  directed_a = 0;
  bit  directed_b = 0;
  bit  spurious_req = 0;
  int  load_idx = 0;
  int  run_idx = 0;
  int  res_cnt = 0;
  int  frame_done_cnt = 0;
  int  me_start_cnt = 0;
  int  win_log_x[W][H];
  int  win_log_y[W][H];
  int  mv_log_x[W][H];
  int  mv_log_y[W][H];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Window origin from the geometric rule: centred on the MB, kept inside the frame.
  function automatic int modelWin(input int mb, input int frame_mbs);
    int v;
    int mx;
    v  = mb * MD - (SD - MD) / 2;
    mx = frame_mbs * MD - SD;
    if (v < 0) v = 0;
    if (v > mx) v = mx;
    return v;
  endfunction

  // Loader responder: checks requested coordinates, answers after a latency.
  initial begin
    bit seen;
    int cnt;
    bit nxt_done;
    int mx, my;
    seen = 0;
    cnt = 0;
    ld_done = 1'b0;
    forever begin
      @(negedge clk);
      nxt_done = 0;
      if (!rst_n) begin
        seen = 0;
      end else begin
        if (ld_req && !seen && !ld_done) begin
          mx = load_idx % W;
          my = load_idx / W;
          load_idx++;
          checkOutput("ld_mb_x", int'(ld_mb_x), mx * MD);
          checkOutput("ld_mb_y", int'(ld_mb_y), my * MD);
          checkOutput("ld_win_x", int'(ld_win_x), modelWin(mx, W));
          checkOutput("ld_win_y", int'(ld_win_y), modelWin(my, H));
          if (my < H) begin
            win_log_x[mx][my] = int'(ld_win_x);
            win_log_y[mx][my] = int'(ld_win_y);
          end
          seen = 1;
          cnt = rand_lat ? int'($urandom_range(0, 5)) : ld_lat - 1;
        end
        if (seen) begin
          if (cnt == 0) begin
            nxt_done = 1;
            seen = 0;
          end else begin
            cnt--;
          end
        end
      end
      @(posedge clk);
      #1;
      ld_done = nxt_done;
    end
  end

  // `me` responder: on start, waits, returns an offset and pushes the expected result.
  initial begin
    bit pend;
    int cnt;
    bit nd;
    int vx, vy, sd, mx, my;
    exp_t e;
    pend = 0;
    cnt = 0;
    vx = 0;
    vy = 0;
    sd = 0;
    me_done = 1'b0;
    me_mv_x = '0;
    me_mv_y = '0;
    me_min_sad = '0;
    forever begin
      @(negedge clk);
      nd = 0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (me_start) begin
          me_start_cnt++;
          pend = 1;
          cnt = rand_lat ? int'($urandom_range(0, 5)) : me_lat - 1;
        end
        if (pend) begin
          if (cnt == 0) begin
            nd = 1;
            pend = 0;
            mx = run_idx % W;
            my = run_idx / W;
            run_idx++;
            vx = int'($urandom_range(0, SD - MD));
            vy = int'($urandom_range(0, SD - MD));
            if (directed_a && mx == 0 && my == 0) begin vx = 0; vy = 0; end
            if (directed_a && mx == 3 && my == 2) begin vx = 16; vy = 16; end
            if (directed_a && mx == 7 && my == 5) begin vx = 32; vy = 32; end
            if (directed_b && mx == 7 && my == 5) begin vx = 0; vy = 0; end
            if (directed_b && mx == 0 && my == 0) begin vx = 32; vy = 0; end
            sd = int'($urandom_range(0, 65535));
            e.mb_x = mx;
            e.mb_y = my;
            e.mv_x = modelWin(mx, W) + vx - mx * MD;
            e.mv_y = modelWin(my, H) + vy - my * MD;
            e.sad  = sd;
            sb.push_back(e);
          end else begin
            cnt--;
          end
        end else if (spurious_req && ld_req && !ld_done) begin
          nd = 1;
          spurious_req = 0;
          vx = 13;
          vy = 29;
          sd = 16'hDEAD;
        end
      end
      @(posedge clk);
      #1;
      me_done = nd;
      if (nd) begin
        me_mv_x = 6'(vx);
        me_mv_y = 6'(vy);
        me_min_sad = 16'(sd);
      end
    end
  end

  // Consumer ready: always, random, or held off.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_done) frame_done_cnt++;
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_result: got mb (%0d,%0d), expected none", res_mb_x, res_mb_y);
          end else begin
            e = sb.pop_front();
            checkOutput("res_mb_x", int'(res_mb_x), e.mb_x);
            checkOutput("res_mb_y", int'(res_mb_y), e.mb_y);
            checkOutput("res_mv_x", int'($signed(res_mv_x)), e.mv_x);
            checkOutput("res_mv_y", int'($signed(res_mv_y)), e.mv_y);
            checkOutput("res_sad", int'(res_sad), e.sad);
            mv_log_x[e.mb_x][e.mb_y] = int'($signed(res_mv_x));
            mv_log_y[e.mb_x][e.mb_y] = int'($signed(res_mv_y));
            res_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input bit b2b, input bit poke, input bit stall);
    int r0, f0, s0, t;
    exp_t e;
    load_idx = 0;
    run_idx = 0;
    r0 = res_cnt;
    f0 = frame_done_cnt;
    s0 = me_start_cnt;
    if (stall) ready_mode = 2;
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", int'(busy), 1);
    t = 0;
    while (frame_done_cnt == f0 && t < FRAME_LIMIT) begin
      @(posedge clk);
      t++;
      if (poke && t == 100) begin
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        t++;
        #1;
        frame_start = 1'b0;
        @(negedge clk);
        checkOutput("busy_during_poke", int'(busy), 1);
      end
      if (stall && t == 40) begin
        @(negedge clk);
        checkOutput("stall_me_starts", me_start_cnt - s0, 1);
        checkOutput("stall_me_start_low", int'(me_start), 0);
        checkOutput("stall_res_valid", int'(res_valid), 1);
        checkOutput("stall_sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb[0];
          checkOutput("stall_res_mv_x", int'($signed(res_mv_x)), e.mv_x);
          checkOutput("stall_res_sad", int'(res_sad), e.sad);
        end
        ready_mode = 0;
      end
    end
    if (t >= FRAME_LIMIT) begin
      checkOutput("frame_timeout", t, 0);
    end
    @(negedge clk);
    checkOutput("busy_after_frame", int'(busy), 0);
    checkOutput("results_per_frame", res_cnt - r0, NMB);
    checkOutput("frame_done_pulses", frame_done_cnt - f0, 1);
    checkOutput("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    int t, r0, s0;
    rst_n = 1'b1;
    frame_start = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_ld_req", int'(ld_req), 0);
    checkOutput("reset_me_start", int'(me_start), 0);
    checkOutput("reset_res_valid", int'(res_valid), 0);
    checkOutput("reset_frame_done", int'(frame_done), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] frame A: directed vectors, frame_start while busy, spurious me_done");
    directed_a = 1;
    spurious_req = 1;
    applyStimulus(0, 1, 0);
    directed_a = 0;
    checkOutput("spurious_consumed", int'(spurious_req), 0);
    checkOutput("win_0_0_x", win_log_x[0][0], 0);
    checkOutput("win_0_0_y", win_log_y[0][0], 0);
    checkOutput("mv_0_0_x", mv_log_x[0][0], 0);
    checkOutput("mv_0_0_y", mv_log_y[0][0], 0);
    checkOutput("win_3_2_x", win_log_x[3][2], 32);
    checkOutput("win_3_2_y", win_log_y[3][2], 16);
    checkOutput("mv_3_2_x", mv_log_x[3][2], 0);
    checkOutput("mv_3_2_y", mv_log_y[3][2], 0);
    checkOutput("win_7_5_x", win_log_x[7][5], 80);
    checkOutput("win_7_5_y", win_log_y[7][5], 48);
    checkOutput("mv_7_5_x", mv_log_x[7][5], 0);
    checkOutput("mv_7_5_y", mv_log_y[7][5], 0);

    $display("[TB] frame B: back-to-back, extreme vectors");
    directed_b = 1;
    applyStimulus(1, 0, 0);
    directed_b = 0;
    checkOutput("mv_7_5_neg_x", mv_log_x[7][5], -32);
    checkOutput("mv_7_5_neg_y", mv_log_y[7][5], -32);
    checkOutput("mv_0_0_pos_x", mv_log_x[0][0], 32);
    checkOutput("mv_0_0_pos_y", mv_log_y[0][0], 0);

    $display("[TB] frame C: consumer stalled for 40 cycles");
    applyStimulus(0, 0, 1);

    $display("[TB] frames D/E: random latencies and random ready");
    rand_lat = 1;
    ready_mode = 1;
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    rand_lat = 0;
    ready_mode = 0;

    $display("[TB] reset in the middle of a frame");
    load_idx = 0;
    run_idx = 0;
    r0 = res_cnt;
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    t = 0;
    while (res_cnt - r0 < 3 && t < FRAME_LIMIT) begin
      @(posedge clk);
      t++;
    end
    s0 = me_start_cnt;
    while (me_start_cnt == s0 && t < FRAME_LIMIT) begin
      @(posedge clk);
      t++;
    end
    if (t >= FRAME_LIMIT) checkOutput("reset_wait_timeout", t, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_ld_req", int'(ld_req), 0);
    checkOutput("midrst_me_start", int'(me_start), 0);
    checkOutput("midrst_res_valid", int'(res_valid), 0);
    checkOutput("midrst_frame_done", int'(frame_done), 0);
    checkOutput("midrst_ld_mb_x", int'(ld_mb_x), 0);
    checkOutput("midrst_ld_win_y", int'(ld_win_y), 0);
    checkOutput("midrst_res_mv_x", int'(res_mv_x), 0);
    checkOutput("midrst_res_sad", int'(res_sad), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] frame F: restart after reset");
    applyStimulus(0, 0, 0);

    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("total_frame_done", frame_done_cnt, 6);
    checkOutput("final_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
